// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DBG and RAM signal bundle
// for the shared data-RAM arbiter.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_we;
   logic              dbg_lock;
   logic [31:0]       dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   logic [ADDR_W-1:0] ram_a;
   logic [DATA_W-1:0] ram_d;
   logic              ram_we;
   logic [DATA_W-1:0] ram_spo;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  ram_a, ram_d, ram_we,
      output ram_spo
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output ram_a, ram_d, ram_we,
      input  ram_spo
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between
// the MEM stage and the debug/loader port.
module dmem_arbiter #(
   parameter int ADDR_W    = 6,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   typedef enum logic {
      WIN_CPU = 1'b0,
      WIN_DBG = 1'b1
   } winner_e;

   winner_e          last_winner;
   logic             lock_active;
   logic [CNT_W-1:0] burst_cnt;
   logic             burst_ok;
   logic             cpu_win;
   logic             dbg_win;
   logic             unused_addr_bits;

   // Per-cycle grant: single requester wins, locked DBG
   // burst wins until the limit, otherwise round-robin.
   always_comb begin
      cpu_win  = 1'b0;
      dbg_win  = 1'b0;
      burst_ok = lock_active && (burst_cnt < CNT_MAX);
      unique case (1'b1)
         (bus.cpu_req && !bus.dbg_req): cpu_win = 1'b1;
         (!bus.cpu_req && bus.dbg_req): dbg_win = 1'b1;
         (bus.cpu_req && bus.dbg_req && burst_ok):
            dbg_win = 1'b1;
         (bus.cpu_req && bus.dbg_req && !burst_ok): begin
            if (last_winner == WIN_DBG) cpu_win = 1'b1;
            else                        dbg_win = 1'b1;
         end
         default: ;
      endcase
   end

   // RAM mux follows the winner; idle cycles park on CPU.
   always_comb begin
      if (dbg_win) begin
         bus.ram_a = bus.dbg_addr[ADDR_W+1:2];
         bus.ram_d = bus.dbg_wdata;
      end else begin
         bus.ram_a = bus.cpu_addr[ADDR_W+1:2];
         bus.ram_d = bus.cpu_wdata;
      end
      bus.ram_we = (dbg_win & bus.dbg_we)
                 | (cpu_win & bus.cpu_we);
   end

   assign bus.cpu_gnt   = cpu_win;
   assign bus.dbg_gnt   = dbg_win;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_win;

   assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2],
                               bus.cpu_addr[1:0],
                               bus.dbg_addr[31:ADDR_W+2],
                               bus.dbg_addr[1:0]};

   // Capture read data for the granted reader; 1-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.cpu_rvalid <= 1'b0;
         bus.dbg_rvalid <= 1'b0;
         bus.cpu_rdata  <= '0;
         bus.dbg_rdata  <= '0;
      end else begin
         bus.cpu_rvalid <= cpu_win & ~bus.cpu_we;
         bus.dbg_rvalid <= dbg_win & ~bus.dbg_we;
         if (cpu_win && !bus.cpu_we) bus.cpu_rdata <= bus.ram_spo;
         if (dbg_win && !bus.dbg_we) bus.dbg_rdata <= bus.ram_spo;
      end
   end

   // Track last winner and the saturating DBG burst count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_winner <= WIN_DBG;
         lock_active <= 1'b0;
         burst_cnt   <= '0;
      end else if (cpu_win) begin
         last_winner <= WIN_CPU;
         lock_active <= 1'b0;
         burst_cnt   <= '0;
      end else if (dbg_win) begin
         last_winner <= WIN_DBG;
         if (bus.dbg_lock) begin
            lock_active <= 1'b1;
            if (bus.cpu_req && burst_cnt != CNT_MAX)
               burst_cnt <= burst_cnt + 1'b1;
         end else begin
            lock_active <= 1'b0;
            burst_cnt   <= '0;
         end
      end else begin
         lock_active <= 1'b0;
         burst_cnt   <= '0;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for
// the shared data-RAM arbiter.
module tb_dmem_arbiter;
   logic clk;
   logic reset;
   int   chk_cnt;
   int   pass_cnt;

   dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   dmem_arbiter #(
      .ADDR_W(6), .DATA_W(32), .MAX_BURST(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Read-only RAM contents: word 2 holds 0xDEADBEEF.
   function automatic logic [31:0] rom(input logic [5:0] a);
      if (a == 6'd2) return 32'hDEAD_BEEF;
      return 32'hA5A5_0000 | {26'h0, a};
   endfunction

   assign bus.ram_spo = rom(bus.ram_a);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      chk_cnt++;
      if (bus.cpu_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
         $display("FAIL reset_rvalid got %b/%b want 0/0",
                  bus.cpu_rvalid, bus.dbg_rvalid);
      end else pass_cnt++;
      chk_cnt++;
      if (bus.cpu_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin
         $display("FAIL reset_rdata got %h/%h want 0/0",
                  bus.cpu_rdata, bus.dbg_rdata);
      end else pass_cnt++;
      chk_cnt++;
      if (bus.cpu_gnt !== 1'b0 || bus.dbg_gnt !== 1'b0 ||
          bus.ram_we !== 1'b0) begin
         $display("FAIL reset_gnt got %b%b%b want 000",
                  bus.cpu_gnt, bus.dbg_gnt, bus.ram_we);
      end else pass_cnt++;
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_cpu_read();
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_0008;
      #2;
      chk_cnt++;
      if (bus.cpu_gnt !== 1'b1 || bus.ram_a !== 6'd2 ||
          bus.cpu_stall !== 1'b0 || bus.ram_we !== 1'b0) begin
         $display("FAIL cpu_read_gnt got g%b a%0d s%b we%b want g1 a2 s0 we0",
                  bus.cpu_gnt, bus.ram_a, bus.cpu_stall, bus.ram_we);
      end else pass_cnt++;
      step();
      bus.cpu_req = 1'b0;
      chk_cnt++;
      if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF ||
          bus.cpu_stall !== 1'b0) begin
         $display("FAIL cpu_read_data got v%b %h s%b want v1 deadbeef s0",
                  bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_stall);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEAD_BEEF) begin
         $display("FAIL cpu_read_pulse got v%b %h want v0 deadbeef",
                  bus.cpu_rvalid, bus.cpu_rdata);
      end else pass_cnt++;
   endtask

   task automatic test_dbg_write();
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 32'h0000_00FC;
      bus.dbg_wdata = 32'h1234_5678;
      #2;
      chk_cnt++;
      if (bus.dbg_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 ||
          bus.ram_we !== 1'b1 || bus.ram_a !== 6'd63 ||
          bus.ram_d !== 32'h1234_5678) begin
         $display("FAIL dbg_write got g%b%b we%b a%0d d%h want g01 we1 a63 d12345678",
                  bus.cpu_gnt, bus.dbg_gnt, bus.ram_we, bus.ram_a, bus.ram_d);
      end else pass_cnt++;
      step();
      bus.dbg_req = 1'b0;
      bus.dbg_we  = 1'b0;
      chk_cnt++;
      if (bus.dbg_rvalid !== 1'b0) begin
         $display("FAIL dbg_write_rvalid got %b want 0", bus.dbg_rvalid);
      end else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic exp_cpu;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_0010;
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_lock = 1'b0;
      bus.dbg_addr = 32'h0000_0020;
      for (int i = 0; i < 4; i++) begin
         exp_cpu = (i % 2 == 0);
         #2;
         chk_cnt++;
         if (bus.cpu_gnt !== exp_cpu || bus.dbg_gnt !== !exp_cpu ||
             bus.cpu_stall !== !exp_cpu ||
             bus.ram_a !== (exp_cpu ? 6'd4 : 6'd8)) begin
            $display("FAIL rr_gnt%0d got g%b%b s%b a%0d want g%b%b s%b",
                     i, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall,
                     bus.ram_a, exp_cpu, !exp_cpu, !exp_cpu);
         end else pass_cnt++;
         step();
         chk_cnt++;
         if (bus.cpu_rvalid !== exp_cpu || bus.dbg_rvalid !== !exp_cpu ||
             (exp_cpu && bus.cpu_rdata !== 32'hA5A5_0004) ||
             (!exp_cpu && bus.dbg_rdata !== 32'hA5A5_0008)) begin
            $display("FAIL rr_rvalid%0d got v%b%b %h %h",
                     i, bus.cpu_rvalid, bus.dbg_rvalid,
                     bus.cpu_rdata, bus.dbg_rdata);
         end else pass_cnt++;
      end
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b0;
      step();
   endtask

   task automatic test_burst_lock();
      int run;
      int max_run;
      run     = 0;
      max_run = 0;
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_lock = 1'b1;
      bus.dbg_addr = 32'h0000_0040;
      #2;
      chk_cnt++;
      if (bus.dbg_gnt !== 1'b1) begin
         $display("FAIL burst_first got %b want 1", bus.dbg_gnt);
      end else pass_cnt++;
      step();
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_000C;
      for (int k = 1; k <= 5; k++) begin
         bus.dbg_addr = 32'h0000_0040 + 32'(k * 4);
         #2;
         if (bus.cpu_stall) run++;
         else run = 0;
         if (run > max_run) max_run = run;
         chk_cnt++;
         if (bus.cpu_gnt !== (k == 5) || bus.dbg_gnt !== (k != 5)) begin
            $display("FAIL burst_gnt%0d got g%b%b want g%b%b",
                     k, bus.cpu_gnt, bus.dbg_gnt, k == 5, k != 5);
         end else pass_cnt++;
         step();
         if (k == 5) bus.cpu_req = 1'b0;
      end
      chk_cnt++;
      if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hA5A5_0003) begin
         $display("FAIL burst_cpu_data got v%b %h want v1 a5a50003",
                  bus.cpu_rvalid, bus.cpu_rdata);
      end else pass_cnt++;
      chk_cnt++;
      if (max_run > 5 || max_run < 1) begin
         $display("FAIL burst_stall_run got %0d want 1..5", max_run);
      end else pass_cnt++;
      for (int k = 6; k < 8; k++) begin
         bus.dbg_addr = 32'h0000_0040 + 32'(k * 4);
         #2;
         chk_cnt++;
         if (bus.dbg_gnt !== 1'b1) begin
            $display("FAIL burst_tail%0d got %b want 1", k, bus.dbg_gnt);
         end else pass_cnt++;
         step();
      end
      bus.dbg_req  = 1'b0;
      bus.dbg_lock = 1'b0;
      chk_cnt++;
      if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hA5A5_0017) begin
         $display("FAIL burst_last_data got v%b %h want v1 a5a50017",
                  bus.dbg_rvalid, bus.dbg_rdata);
      end else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid();
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_lock = 1'b1;
      bus.dbg_addr = 32'h0000_0030;
      #2;
      chk_cnt++;
      if (bus.dbg_gnt !== 1'b1) begin
         $display("FAIL rmid_gnt got %b want 1", bus.dbg_gnt);
      end else pass_cnt++;
      step();
      bus.dbg_req  = 1'b0;
      bus.dbg_lock = 1'b0;
      chk_cnt++;
      if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hA5A5_000C) begin
         $display("FAIL rmid_pre got v%b %h want v1 a5a5000c",
                  bus.dbg_rvalid, bus.dbg_rdata);
      end else pass_cnt++;
      #1;
      reset = 1'b0;
      #1;
      chk_cnt++;
      if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0 ||
          bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
         $display("FAIL rmid_async got v%b%b %h %h want v00 0 0",
                  bus.cpu_rvalid, bus.dbg_rvalid,
                  bus.cpu_rdata, bus.dbg_rdata);
      end else pass_cnt++;
      step();
      reset = 1'b1;
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_0014;
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 32'h0000_0018;
      #2;
      chk_cnt++;
      if (bus.cpu_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
         $display("FAIL rmid_tie got g%b%b want g10",
                  bus.cpu_gnt, bus.dbg_gnt);
      end else pass_cnt++;
      step();
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b0;
   endtask

   task automatic test_idle();
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_addr = 32'h0000_0024;
      step();
      bus.dbg_req  = 1'b0;
      bus.cpu_addr = 32'h0000_001C;
      step();
      chk_cnt++;
      if (bus.ram_we !== 1'b0 || bus.cpu_gnt !== 1'b0 ||
          bus.dbg_gnt !== 1'b0 || bus.ram_a !== 6'd7) begin
         $display("FAIL idle_bus got we%b g%b%b a%0d want we0 g00 a7",
                  bus.ram_we, bus.cpu_gnt, bus.dbg_gnt, bus.ram_a);
      end else pass_cnt++;
      chk_cnt++;
      if (bus.cpu_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
         $display("FAIL idle_rvalid got %b%b want 00",
                  bus.cpu_rvalid, bus.dbg_rvalid);
      end else pass_cnt++;
      chk_cnt++;
      if (bus.cpu_rdata !== 32'hA5A5_0005 ||
          bus.dbg_rdata !== 32'hA5A5_0009) begin
         $display("FAIL idle_hold got %h %h want a5a50005 a5a50009",
                  bus.cpu_rdata, bus.dbg_rdata);
      end else pass_cnt++;
   endtask

   initial begin
      chk_cnt       = 0;
      pass_cnt      = 0;
      reset         = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h0;
      bus.cpu_wdata = 32'h0;
      bus.dbg_req   = 1'b0;
      bus.dbg_we    = 1'b0;
      bus.dbg_lock  = 1'b0;
      bus.dbg_addr  = 32'h0;
      bus.dbg_wdata = 32'h0;
      test_reset();
      test_cpu_read();
      test_dbg_write();
      test_round_robin();
      test_burst_lock();
      test_reset_mid();
      test_idle();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DataRAM between the pipeline MEM stage (CPU port) and a debug/program-loader port (DBG port).
- Arbitrates per cycle: round-robin on contention, optional bounded DBG bursts.
- Drives the RAM address, write data and write enable; returns registered read data with 1-cycle latency.
- Raises cpu_stall so the core freezes while the CPU port is denied.

Parameters:
- ADDR_W, 6, RAM word-address width; taken from byte address bits [ADDR_W+1:2].
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive locked DBG grants while CPU is waiting (1..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  32  byte address
- cpu_wdata  input  DATA_W  write data
- cpu_gnt  output  1  access accepted this cycle (combinational)
- cpu_stall  output  1  cpu_req & ~cpu_gnt
- cpu_rvalid  output  1  read data valid (registered pulse)
- cpu_rdata  output  DATA_W  registered read data
- dbg_req  input  1  DBG access request
- dbg_we  input  1  1 = write, 0 = read
- dbg_lock  input  1  request to keep the grant for back-to-back accesses
- dbg_addr  input  32  byte address
- dbg_wdata  input  DATA_W  write data
- dbg_gnt  output  1  access accepted this cycle (combinational)
- dbg_rvalid  output  1  read data valid (registered pulse)
- dbg_rdata  output  DATA_W  registered read data
- ram_a  output  ADDR_W  RAM word address
- ram_d  output  DATA_W  RAM write data
- ram_we  output  1  RAM write enable
- ram_spo  input  DATA_W  RAM asynchronous read data

Behaviour:
- Reset (reset=0, async): cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0, burst_cnt=0, lock_active=0, last_winner=DBG (CPU wins the first tie).
- Grant rules, combinational each cycle:
  - No requests: no grant; ram_we=0; ram_a/ram_d = CPU inputs.
  - Single requester: that requester is granted.
  - Both requesting, lock_active=1 and burst_cnt<MAX_BURST: DBG is granted.
  - Both requesting otherwise: grant goes to the port opposite last_winner.
- Exactly one grant or none; gnt is never asserted without the matching req.
- RAM muxing: ram_a = winner addr[ADDR_W+1:2]; ram_d = winner wdata; ram_we = winner we & gnt. Unused address bits are ignored; no misalignment checking.
- Read return: on a granted read, the clock edge captures ram_spo into the winner's rdata and pulses its rvalid high for exactly 1 cycle.
  - Latency: grant cycle N, data visible in cycle N+1.
  - rdata holds its value until the next read by that port.
  - A write never pulses rvalid.
- State updates at each edge with a grant:
  - last_winner <= winner.
  - DBG granted with dbg_lock=1: lock_active <= 1; burst_cnt <= burst_cnt+1 if cpu_req, otherwise burst_cnt holds.
  - DBG granted with dbg_lock=0, or CPU granted: lock_active <= 0; burst_cnt <= 0.
  - Cycle with no grant: lock_active <= 0; burst_cnt <= 0.
- burst_cnt saturates at MAX_BURST; it never wraps.
- Burst limit: once burst_cnt reaches MAX_BURST with CPU waiting, CPU wins the next tie, then the counter clears.
- Simultaneous read/write to the same address by different ports cannot occur, because only one port is granted per cycle.
- Reset mid-operation: a pending rvalid is dropped and the lock is cleared.
- cpu_stall is purely combinational and is guaranteed deasserted within MAX_BURST+1 cycles of cpu_req rising.

Test Plan:
- Reset, then CPU read of addr 0x0000_0008 while RAM word 2 = 0xDEAD_BEEF:
  - same cycle: cpu_gnt=1, ram_a=2;
  - next cycle: cpu_rvalid=1, cpu_rdata=0xDEAD_BEEF;
  - cpu_stall=0 throughout.
- DBG write of 0x1234_5678 to 0x0000_00FC, DBG alone: dbg_gnt=1, ram_we=1, ram_a=63, ram_d=0x1234_5678, dbg_rvalid stays 0.
- Both request continuously with no lock, starting from reset: grants alternate CPU, DBG, CPU, DBG; cpu_stall=1 on the DBG cycles only.
- DBG holds dbg_lock=1 with 8 reads while CPU requests, MAX_BURST=4: after the first DBG grant, 4 locked DBG grants follow, then 1 CPU grant; cpu_stall never exceeds 5 consecutive cycles.
- Assert reset=0 in the cycle after a granted DBG read:
  - dbg_rvalid=0 and all outputs at reset values immediately;
  - after release, a tie grants CPU first.
- Idle cycle: ram_we=0, both gnt=0, both rvalid=0; rdata values are retained from the previous reads.
